// File: rtl/cam_buf_wr_nbuf_if.sv
// BRAM write-port bundle between the camera frame writer and the input
// frame buffers.
//   wr_en      : write strobe (oWrEn)
//   wr_addr    : linear pixel address, line*H_ACT+col (oWrAddr)
//   wr_data    : assembled RGB565 pixel (oWrData)
//   wr_buf_sel : frame buffer targeted by the current frame (oWrBufSel)
// master: the writer drives the bundle; slave: the BRAM side observes it.
interface cam_buf_wr_nbuf_if #(
  parameter int ADDR_W = 17,
  parameter int BUF_W  = 1
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [BUF_W-1:0]  wr_buf_sel;

  modport master (output wr_en, wr_addr, wr_data, wr_buf_sel);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_buf_sel);
endinterface

// File: rtl/cam_buf_wr_nbuf.sv
// Camera frame writer for NUM_BUF round-robin frame buffers.
// Packs byte-serial camera data into 16-bit RGB565 words and writes whole
// frames into the next free buffer. Full flags are set on completion and
// cleared by the reader's release pulses; frames with no free buffer, or
// frames that end short, are dropped.
// Ports:
//   iClk, iRst        pixel clock, asynchronous active-high reset
//   iSwapByte         0: first byte of a pair is [15:8], 1: first is [7:0]
//   iVsync, iHsync    1 = vertical blanking / 1 = line active
//   iData             camera byte
//   iBufRelease       per-buffer release pulse from the reader
//   wr                BRAM write bundle (enable, address, data, buffer)
//   oBufFull          per-buffer full flags
//   oLastBuf          most recently completed buffer
//   oFrDone, oFrDrop  one-cycle frame completed / dropped pulses
// Optional: define TEST_PATTERN_EN to replace camera data with
// {col[7:0], line[7:0]} for every written word.
module cam_buf_wr_nbuf #(
  parameter int H_ACT   = 480,
  parameter int V_ACT   = 272,
  parameter int NUM_BUF = 2,
  parameter int ADDR_W  = 17,
  parameter int BUF_W   = 1
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iSwapByte,
  input  logic               iVsync,
  input  logic               iHsync,
  input  logic [7:0]         iData,
  input  logic [NUM_BUF-1:0] iBufRelease,
  cam_buf_wr_nbuf_if.master  wr,
  output logic [NUM_BUF-1:0] oBufFull,
  output logic [BUF_W-1:0]   oLastBuf,
  output logic               oFrDone,
  output logic               oFrDrop
);
  localparam int          FRAME_WORDS = H_ACT * V_ACT;
  localparam int          CNT_W       = ADDR_W + 1;
  localparam int          COL_W       = $clog2(H_ACT + 1);
  localparam int          LINE_W      = $clog2(V_ACT + 1);
  localparam int unsigned NB          = NUM_BUF;

  typedef enum logic [2:0] {
    WAIT_BLANK, IDLE, SELECT, CAPTURE, DROP, FINISH
  } state_t;

  state_t              state, state_next;
  logic                vsync_q, hsync_q;
  logic [BUF_W-1:0]    next_ptr;
  logic                phase;
  logic [7:0]          first_byte;
  logic [COL_W-1:0]    col;
  logic [LINE_W-1:0]   line;
  logic [CNT_W-1:0]    word_cnt;
  logic                found;
  logic [BUF_W-1:0]    pick;
  logic [NUM_BUF-1:0]  full_rel;
  logic [NUM_BUF-1:0]  sel_mask;
  logic                in_window;
  logic [15:0]         word;

`ifdef TEST_PATTERN_EN
  logic [15:0] col_ext, line_ext;
  assign col_ext  = 16'(col);
  assign line_ext = 16'(line);
  assign word     = {col_ext[7:0], line_ext[7:0]};
`else
  assign word = iSwapByte ? {iData, first_byte} : {first_byte, iData};
`endif

  assign in_window = (col < COL_W'(H_ACT)) && (line < LINE_W'(V_ACT));
  assign full_rel  = oBufFull & ~iBufRelease;

  // Round-robin scan for the first free buffer starting at next_ptr.
  always_comb begin
    int unsigned sum;
    logic [BUF_W-1:0] idx;
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    idx   = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      sum = 32'(next_ptr) + k;
      if (sum >= NB) sum = sum - NB;
      idx = BUF_W'(sum);
      if (!found && !oBufFull[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    sel_mask = '0;
    sel_mask[wr.wr_buf_sel] = 1'b1;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= WAIT_BLANK;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_BLANK: if (iVsync) state_next = IDLE;
      IDLE:       if (vsync_q && !iVsync) state_next = SELECT;
      // Vsync rising while selecting still goes through FINISH, where the
      // zero word count turns it into a short-frame drop.
      SELECT:     if (!found) state_next = DROP;
                  else if (iVsync) state_next = FINISH;
                  else state_next = CAPTURE;
      CAPTURE:    if (iVsync) state_next = FINISH;
      DROP:       if (iVsync) state_next = IDLE;
      FINISH:     state_next = IDLE;
      default:    state_next = WAIT_BLANK;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      next_ptr      <= '0;
      phase         <= 1'b0;
      first_byte    <= '0;
      col           <= '0;
      line          <= '0;
      word_cnt      <= '0;
      wr.wr_en      <= 1'b0;
      wr.wr_addr    <= '0;
      wr.wr_data    <= '0;
      wr.wr_buf_sel <= '0;
      oBufFull      <= '0;
      oLastBuf      <= '0;
      oFrDone       <= 1'b0;
      oFrDrop       <= 1'b0;
    end else begin
      vsync_q  <= iVsync;
      hsync_q  <= iHsync;
      wr.wr_en <= 1'b0;
      oFrDone  <= 1'b0;
      oFrDrop  <= 1'b0;
      oBufFull <= full_rel;
      case (state)
        SELECT: begin
          word_cnt   <= '0;
          wr.wr_addr <= '0;
          col        <= '0;
          line       <= '0;
          phase      <= 1'b0;
          if (found) wr.wr_buf_sel <= pick;
          else       oFrDrop       <= 1'b1;
        end
        CAPTURE: if (!iVsync) begin
          if (!iHsync) begin
            phase <= 1'b0;
          end else if (!phase) begin
            first_byte <= iData;
            phase      <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (in_window) begin
              wr.wr_en   <= 1'b1;
              wr.wr_addr <= word_cnt[ADDR_W-1:0];
              wr.wr_data <= word;
              word_cnt   <= word_cnt + CNT_W'(1);
            end
            // Column saturates at H_ACT: every word beyond it is dropped.
            if (col != COL_W'(H_ACT)) col <= col + COL_W'(1);
          end
          if (hsync_q && !iHsync && col != '0) begin
            col <= '0;
            if (line != LINE_W'(V_ACT)) line <= line + LINE_W'(1);
          end
        end
        FINISH: begin
          if (word_cnt == CNT_W'(FRAME_WORDS)) begin
            // Set is applied after release so a same-cycle release loses.
            oBufFull <= full_rel | sel_mask;
            oLastBuf <= wr.wr_buf_sel;
            oFrDone  <= 1'b1;
            if (wr.wr_buf_sel == BUF_W'(NUM_BUF - 1)) next_ptr <= '0;
            else next_ptr <= wr.wr_buf_sel + BUF_W'(1);
          end else begin
            oFrDrop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
